// File: rtl/midi_msg_tx_pkg.sv
// Shared types and helpers for the MIDI message transmitter.
package midi_msg_tx_pkg;

  localparam int MIDI_BAUD = 31250;
  localparam int CLK_HZ    = 50_000_000;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

  // Number of bytes in a message with this status byte; 0 means reject.
  function automatic logic [1:0] midi_msg_len(input logic [7:0] status);
    if (!status[7]) return 2'd0;
    if (status < 8'hC0) return 2'd3;
    if (status < 8'hE0) return 2'd2;
    if (status < 8'hF0) return 2'd3;
    if (status == 8'hF6 || status >= 8'hF8) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic is_channel(input logic [7:0] status);
    return (status >= 8'h80) && (status < 8'hF0);
  endfunction

endpackage

// File: rtl/midi_msg_tx_if.sv
// Message handshake bundle: packed 24-bit MIDI message with valid/ready.
interface midi_msg_tx_if;
  logic [23:0] i_msg;
  logic        i_valid;
  logic        o_ready;

  modport master (output i_msg, output i_valid, input o_ready);
  modport slave  (input i_msg, input i_valid, output o_ready);
endinterface

// File: rtl/midi_msg_tx_uart_tx_byte.sv
// Single-byte UART serialiser (start, 8 data LSB first, stop). A start seen
// in the last STOP cycle chains the next byte with no idle gap.
module uart_tx_byte
  import midi_msg_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1600,
  parameter int CNT_W        = 11
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       done,
  output logic       serial,
  output tx_state_e  state
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e        state_nx;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             tick;
  logic             load;

  assign tick = (cnt == LAST);
  assign load = start && (state == IDLE || (state == STOP && tick));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = START;
      START:   if (tick) state_nx = DATA;
      DATA:    if (tick && bit_idx == 3'd7) state_nx = STOP;
      STOP:    if (tick) state_nx = start ? START : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    serial = 1'b1;
    done   = 1'b0;
    case (state)
      START:   serial = 1'b0;
      DATA:    serial = shreg[0];
      STOP:    done   = tick;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      if (state == IDLE || tick) cnt <= '0;
      else                       cnt <= cnt + 1'b1;
      if (state == DATA && tick) bit_idx <= bit_idx + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (load)                       shreg <= data;
    else if (state == DATA && tick) shreg <= {1'b0, shreg[7:1]};
  end

endmodule

// File: rtl/midi_msg_tx.sv
// MIDI message transmitter: handshake, length decode and byte sequencing.
// Optional running status is enabled with MIDI_RUNNING_STATUS_EN.
module midi_msg_tx
  import midi_msg_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1600,
  parameter int CNT_W        = 11
) (
  input  logic          CLOCK_50,
  input  logic          reset_n,
  midi_msg_tx_if.slave  bus,
  output logic          o_serial,
  output logic          o_busy,
  output logic          o_err,
  output logic [2:0]    o_state
);

  tx_state_e   state;
  logic [23:0] hold;
  logic [1:0]  byte_idx;
  logic [1:0]  last_idx;
  logic [1:0]  len;
  logic [1:0]  first;
  logic [7:0]  status;
  logic        xfer;
  logic        accept;
  logic        done;
  logic        more;
  logic        start;
  logic [7:0]  tx_byte;

  // Byte 0 is the status; data bytes always go out with bit 7 cleared.
  function automatic logic [7:0] byte_sel(input logic [23:0] msg, input logic [1:0] idx);
    case (idx)
      2'd0:    return msg[23:16];
      2'd1:    return msg[15:8] & 8'h7F;
      default: return msg[7:0] & 8'h7F;
    endcase
  endfunction

  assign status      = bus.i_msg[23:16];
  assign len         = midi_msg_len(status);
  assign bus.o_ready = (state == IDLE);
  assign xfer        = bus.i_valid && bus.o_ready;
  assign accept      = xfer && (len != 2'd0);
  assign more        = (byte_idx != last_idx);

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] last_status;

  assign first = (is_channel(status) && status == last_status) ? 2'd1 : 2'd0;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) last_status <= 8'h00;
    else if (accept) begin
      if (is_channel(status))    last_status <= status;
      else if (status == 8'hF6)  last_status <= 8'h00;
    end
  end
`else
  assign first = 2'd0;
`endif

  always_comb begin
    start   = 1'b0;
    tx_byte = byte_sel(bus.i_msg, first);
    if (accept) begin
      start = 1'b1;
    end else if (done && more) begin
      start   = 1'b1;
      tx_byte = byte_sel(hold, 2'(byte_idx + 2'd1));
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      byte_idx <= 2'd0;
      last_idx <= 2'd0;
      o_err    <= 1'b0;
    end else begin
      o_err <= xfer && (len == 2'd0);
      if (accept) begin
        byte_idx <= first;
        last_idx <= 2'(len - 2'd1);
      end else if (done && more) begin
        byte_idx <= 2'(byte_idx + 2'd1);
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (accept) hold <= bus.i_msg;
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_tx (
    .clk     (CLOCK_50),
    .reset_n (reset_n),
    .start   (start),
    .data    (tx_byte),
    .done    (done),
    .serial  (o_serial),
    .state   (state)
  );

  assign o_busy  = (state != IDLE);
  assign o_state = {1'b0, state};

endmodule

// File: tb/tb_midi_msg_tx.sv
// Self-checking bench for midi_msg_tx with a message-level reference model.
module tb_midi_msg_tx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       o_serial;
  logic       o_busy;
  logic       o_err;
  logic [2:0] o_state;

  midi_msg_tx_if bus();

  midi_msg_tx #(.CLKS_PER_BIT(CPB), .CNT_W(5)) dut (
    .CLOCK_50 (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .o_serial (o_serial),
    .o_busy   (o_busy),
    .o_err    (o_err),
    .o_state  (o_state)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] mdl_last = 8'h00;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected byte stream for one offered message, straight from the message rules.
  task automatic model(input logic [23:0] msg);
    logic [7:0] st;
    int         len;
    st = msg[23:16];
    exp_q.delete();
    if (st < 8'h80)                        len = 0;
    else if (st < 8'hC0)                   len = 3;
    else if (st < 8'hE0)                   len = 2;
    else if (st < 8'hF0)                   len = 3;
    else if (st == 8'hF6 || st >= 8'hF8)   len = 1;
    else                                   len = 0;
    if (len > 0) exp_q.push_back(st);
    if (len > 1) exp_q.push_back(msg[15:8] & 8'h7F);
    if (len > 2) exp_q.push_back(msg[7:0] & 8'h7F);
`ifdef MIDI_RUNNING_STATUS_EN
    if (len > 0) begin
      if (st < 8'hF0) begin
        if (st == mdl_last) void'(exp_q.pop_front());
        mdl_last = st;
      end else if (st == 8'hF6) begin
        mdl_last = 8'h00;
      end
    end
`endif
  endtask

  // Called at a falling edge with the DUT idle; abort_at>0 asserts reset at that cycle.
  task automatic send(input logic [23:0] msg, input int abort_at);
    logic [9:0] exp_f;
    logic [9:0] obs_f;
    int         bad;
    int         ctl_bad;
    int         n;
    model(msg);
    check("idle_before", 32'({bus.o_ready, o_busy, o_serial}), 32'(3'b101));
    bus.i_msg   = msg;
    bus.i_valid = 1'b1;
    @(posedge clk);
    if (exp_q.size() == 0) begin
      @(negedge clk);
      check("err_pulse", 32'(o_err), 32'd1);
      check("reject_idle", 32'({bus.o_ready, o_busy, o_serial, o_state}), 32'(6'b101000));
      bus.i_valid = 1'b0;
      @(negedge clk);
      check("err_clear", 32'({o_err, o_serial, bus.o_ready}), 32'(3'b011));
      return;
    end
    n = 0;
    for (int b = 0; b < exp_q.size(); b++) begin
      exp_f   = {1'b1, exp_q[b], 1'b0};
      obs_f   = '0;
      bad     = 0;
      ctl_bad = 0;
      for (int j = 0; j < 10; j++) begin
        for (int s = 0; s < CPB; s++) begin
          @(negedge clk);
          n++;
          if (s == 0) obs_f[j] = o_serial;
          if (o_serial !== exp_f[j]) bad++;
          if (o_busy !== 1'b1 || bus.o_ready !== 1'b0 || o_err !== 1'b0) ctl_bad++;
          if (n == 1) begin
            bus.i_valid = 1'b0;
            bus.i_msg   = 24'($urandom);
          end
          if (n == abort_at) begin
            reset_n = 1'b0;
            #1;
            check("reset_line", 32'({o_serial, bus.o_ready, o_busy, o_err, o_state}),
                  32'(7'b1100000));
            mdl_last = 8'h00;
            return;
          end
        end
      end
      check("frame", 32'(obs_f), 32'(exp_f));
      check("bit_hold", 32'(bad), 32'd0);
      check("busy_ready", 32'(ctl_bad), 32'd0);
    end
    @(negedge clk);
    check("done_idle", 32'({bus.o_ready, o_busy, o_serial, o_err, o_state}), 32'(7'b1010000));
  endtask

  initial begin
    logic [7:0]  st;
    logic [7:0]  prev_st;
    logic [23:0] m;
    bus.i_valid = 1'b0;
    bus.i_msg   = 24'h0;
    #1;
    check("reset_vals", 32'({o_serial, bus.o_ready, o_busy, o_err, o_state}), 32'(7'b1100000));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    send(24'h903C64, 0);
    send({16'hC005, 8'($urandom)}, 0);
    send({8'hF8, 16'($urandom)}, 0);
    send(24'h7F0000, 0);
    send(24'hF40000, 0);
    send(24'h9040FF, 0);

    send(24'h80407F, 10 * CPB + 50);
    repeat (3) @(negedge clk);
    check("reset_hold", 32'({o_serial, bus.o_ready, o_busy}), 32'(3'b110));
    reset_n = 1'b1;
    @(negedge clk);
    send(24'hB07B00, 0);

    send(24'h903C64, 0);
    send(24'h903E64, 0);
    send(24'hF60000, 0);
    send(24'h903E64, 0);
    send(24'h903E64, 0);

    prev_st = 8'h90;
    for (int k = 0; k < 25; k++) begin
      case ($urandom_range(0, 3))
        0:       st = 8'($urandom);
        1:       st = prev_st;
        default: st = 8'h80 | 8'($urandom);
      endcase
      m = {st, 16'($urandom)};
      send(m, 0);
      prev_st = st;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/midi_msg_tx.md
Name: midi_msg_tx

Overview:
- MIDI transmitter: accepts one packed MIDI message per valid/ready handshake and serialises it as standard MIDI UART frames at 31250 baud.
- Frame format: 1 start bit, 8 data bits LSB first, 1 stop bit; line idles high.
- Mirror of the board's MIDI receive path: takes the same 24-bit packed-message layout that path produces and drives the EX_IO MIDI-out pin.
- Message length (1, 2 or 3 bytes) is decoded from the status byte.

Parameters:
- CLKS_PER_BIT, 1600: CLOCK_50 cycles per serial bit (50 MHz / 31250). Set to 16 in simulation.
- CNT_W, 11: bit-timer width; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous, active-low reset
- i_msg  in  24  [23:16] status, [15:8] data1, [7:0] data2
- i_valid  in  1  message offered
- o_ready  out  1  block can accept a message
- o_serial  out  1  MIDI TX line, idle high
- o_busy  out  1  frame in progress
- o_err  out  1  one-cycle pulse: message rejected
- o_state  out  3  FSM state, for debug/LEDs

Behaviour:
- Reset values (async, immediate): o_serial=1, o_ready=1, o_busy=0, o_err=0, FSM=IDLE, bit timer=0, byte index=0.
- Reset asserted mid-frame: line returns high at once and the message is abandoned. After release, the first frame can start no earlier than 1 clock later.
- Handshake:
  - Transfer occurs on a rising edge with i_valid && o_ready; i_msg is captured into a 24-bit holding register on that edge.
  - Later changes to i_msg have no effect.
  - o_ready=1 only in IDLE.
- Length decode (status = i_msg[23:16]):
  - 0x80-0xBF, 0xE0-0xEF: 3 bytes.
  - 0xC0-0xDF: 2 bytes.
  - 0xF6, 0xF8-0xFF: 1 byte.
  - Bit 7 clear, or 0xF0-0xF5, 0xF7: rejected. o_err pulses the cycle after the handshake, nothing is transmitted, FSM stays in IDLE, and o_ready remains 1.
- Data bytes are sent with bit 7 forced to 0.
- FSM states: IDLE -> START -> DATA -> STOP -> (NEXT byte ? START : IDLE).
  - START: o_serial=0 for CLKS_PER_BIT cycles, beginning the cycle after the handshake (latency 1 clock).
  - DATA: 8 bits LSB first, each held exactly CLKS_PER_BIT cycles.
  - STOP: o_serial=1 for CLKS_PER_BIT cycles.
- Consecutive bytes of one message: no inter-byte gap. The next START begins the cycle after STOP ends.
- o_ready rises the cycle after the final STOP period ends. Back-to-back messages are therefore separated only by that 1 idle clock.
- o_busy=1 in START/DATA/STOP.
- Total duration: N bytes = N*10*CLKS_PER_BIT clocks, plus 1 clock of handshake latency.
- Bit timer counts 0..CLKS_PER_BIT-1 and wraps. Bit index 0..7 and byte index 0..2 never exceed their range.

Optional Feature:
- Macro: MIDI_RUNNING_STATUS_EN
- Defined:
  - A last_status register (reset 0x00) records the last transmitted channel status (0x80-0xEF).
  - An accepted channel message whose status equals last_status omits the status byte and sends only its data bytes (2->1, 3->2).
  - Real-time bytes 0xF8-0xFF leave last_status unchanged; 0xF6 clears it to 0x00.
  - Rejected messages leave last_status unchanged.
- Undefined: the status byte is always sent and no last_status register exists.

Decomposition:
- midi_pkg:
  - tx_state_e enum: IDLE, START, DATA, STOP.
  - MIDI_BAUD = 31250 and CLK_HZ = 50_000_000 constants.
  - Function midi_msg_len(status) returning 0 (reject) or 1-3.
- Sub-module uart_tx_byte: a single-byte serialiser with byte/start in and done pulse out, containing the bit timer and shift register.
- midi_msg_tx owns the handshake, length decode, byte sequencing and running status.

Test Plan (CLKS_PER_BIT=16):
- i_msg=0x903C64 with valid -> 3 frames 0x90, 0x3C, 0x64, each 160 clocks. Start bit goes low 1 clock after the handshake; o_ready returns after 480 clocks.
- i_msg=0xC005 -> 2 frames 0xC0, 0x05 (320 clocks). The data2 field is ignored.
- i_msg=0xF8xxxx -> single frame 0xF8. i_msg=0x7F0000 -> o_err pulse, line stays high, o_ready stays 1.
- reset_n driven low at clock 50 of the second byte of 0x80407F -> o_serial=1 immediately. After release, message 0xB07B00 transmits cleanly.
- i_msg=0x9040FF -> the third frame is 0x7F (bit 7 masked).
- With MIDI_RUNNING_STATUS_EN: 0x903C64 then 0x903E64 -> second message sends only 0x3E, 0x64. Inserting 0xF6 between them restores the 0x90 status byte.
